// File: rtl/framebuffer_store.sv
// framebuffer_store: writes a framed byte stream sequentially into framebuffer RAM port A.
// Define FB_STORE_CHECKSUM_EN to add a modulo-256 checksum of the bytes written in the current frame.
module framebuffer_store #(
  parameter int ADDR_WIDTH  = 12,
  parameter int FRAME_BYTES = 4096,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_strobe,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data_out,
  output logic                  ram_clk_enable,
  output logic                  ram_write,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [7:0]            checksum
);
  typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;
  state_t                state_q;
  logic [7:0]            f0_q, f1_q, f0_d, f1_d, data_q;
  logic [1:0]            cnt_q, cnt_d, rem;
  logic [ADDR_WIDTH-1:0] ptr_q, addr_q;
  logic                  we_q, done_q, ovf_q;
  logic                  pop, push, full, accept, last;
  assign pop    = state_q == ARMED && cnt_q != 2'd0;
  assign push   = rx_strobe && state_q != IDLE;
  assign full   = cnt_q == 2'(FIFO_DEPTH);
  assign accept = push && (!full || pop);
  assign last   = ptr_q == ADDR_WIDTH'(FRAME_BYTES - 1);
  // Two-entry shift FIFO: head is always f0; a same-cycle pop shifts before the push lands.
  assign rem    = cnt_q - 2'(pop);
  assign f0_d   = accept && rem == 2'd0 ? rx_data : pop ? f1_q : f0_q;
  assign f1_d   = accept && rem != 2'd0 ? rx_data : f1_q;
  assign cnt_d  = rem + 2'(accept);
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      f0_q    <= '0;
      f1_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (frame_start) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      f0_q   <= f0_d;
      f1_q   <= f1_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_q | (push && !accept);
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ARMED: if (pop) begin
          addr_q  <= ptr_q;
          data_q  <= f0_q;
          we_q    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          ptr_q   <= last ? '0 : ptr_q + 1'b1;
          done_q  <= last;
          state_q <= last ? IDLE : ARMED;
        end
        default: ;
      endcase
    end
  end
`ifdef FB_STORE_CHECKSUM_EN
  logic [7:0] sum_q;
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) sum_q <= '0;
    else if (frame_start) sum_q <= '0;
    else if (state_q == WRITE) sum_q <= sum_q + data_q;
  end
  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif
  assign ram_address    = addr_q;
  assign ram_data_out   = data_q;
  assign ram_clk_enable = we_q;
  assign ram_write      = we_q;
  assign busy           = state_q != IDLE;
  assign frame_done     = done_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_framebuffer_store.sv
// tb_framebuffer_store: directed scenarios with a write scoreboard for framebuffer_store.
module tb_framebuffer_store;
`ifdef FB_STORE_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_strobe = 1'b0;
  logic        frame_start = 1'b0;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out, checksum, done_csum;
  logic        ram_clk_enable, ram_write, busy, frame_done, overflow;
  logic        prev_we = 1'b0;
  logic [11:0] prev_addr = '0;
  logic [19:0] sb[$];
  logic [19:0] exp_w;
  int          checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0;
  int          base;

  framebuffer_store dut (
    .clk_in(clk), .reset(rst_n), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .frame_start(frame_start), .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_clk_enable(ram_clk_enable), .ram_write(ram_write), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_strobe = 1'b1;
    tick(1);
    rx_strobe = 1'b0;
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (ram_clk_enable || ram_write) begin
      wr_cnt++;
      chk("wr_pair", {30'd0, ram_clk_enable, ram_write}, 32'd3);
      chk("sb_avail", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk("write", {12'd0, ram_address, ram_data_out}, {12'd0, exp_w});
      end
    end
    if (frame_done) begin
      done_cnt++;
      done_csum = checksum;
      chk("done_after_last", {19'd0, prev_we, prev_addr}, {19'd0, 1'b1, 12'hFFF});
    end
    prev_we   = ram_clk_enable;
    prev_addr = ram_address;
  end

  initial begin
    tick(3);
    chk("reset_ctl", {27'd0, busy, frame_done, overflow, ram_clk_enable, ram_write}, 0);
    chk("reset_data", {4'd0, ram_address, ram_data_out, checksum}, 0);
    rst_n = 1'b1;
    tick(2);
    send(8'h11);
    tick(5);
    chk("idle_ignores", 32'(wr_cnt), 0);
    // Scenario 1: three spaced bytes
    start();
    chk("s1_busy", {31'd0, busy}, 1);
    base = wr_cnt;
    sb.push_back({12'd0, 8'hA5});
    sb.push_back({12'd1, 8'h5A});
    sb.push_back({12'd2, 8'hFF});
    send(8'hA5); tick(9);
    send(8'h5A); tick(9);
    send(8'hFF); tick(9);
    drain();
    tick(10);
    chk("s1_wr_cnt", 32'(wr_cnt - base), 3);
    chk("s1_busy_done", {30'd0, busy, frame_done}, 32'd2);
    // Scenario 3: burst of five overflows the two-entry FIFO
    start();
    for (int i = 1; i <= 4; i++) sb.push_back({12'(i - 1), 8'(i)});
    rx_strobe = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      rx_data = 8'(i);
      tick(1);
    end
    rx_strobe = 1'b0;
    drain();
    chk("s3_overflow", {31'd0, overflow}, 1);
    // Scenario 4: restart mid-frame
    for (int i = 4; i < 10; i++) begin
      sb.push_back({12'(i), 8'(i * 7)});
      send(8'(i * 7));
      tick(2);
    end
    drain();
    chk("s4_ovf_sticky", {31'd0, overflow}, 1);
    start();
    chk("s4_ovf_clr", {31'd0, overflow}, 0);
    chk("s4_csum_clr", {24'd0, checksum}, 0);
    base = done_cnt;
    sb.push_back({12'd0, 8'h3C});
    send(8'h3C);
    drain();
    tick(3);
    chk("s4_no_done", 32'(done_cnt - base), 0);
    // Scenario 6b: checksum of a short frame, cleared by frame_start
    start();
    for (int i = 0; i < 3; i++) sb.push_back({12'(i), i == 0 ? 8'h10 : i == 1 ? 8'h20 : 8'hF5});
    send(8'h10); tick(2);
    send(8'h20); tick(2);
    send(8'hF5); tick(2);
    drain();
    chk("s6_csum", {24'd0, checksum}, CS ? 32'h25 : 32'h0);
    start();
    chk("s6_csum_clr", {24'd0, checksum}, 0);
    // Scenario 2 + 6: full frame
    base = done_cnt;
    for (int i = 0; i < 4096; i++) begin
      sb.push_back({12'(i), 8'(i)});
      send(8'(i));
      tick(2);
    end
    for (int i = 0; i < 100 && done_cnt == base; i++) tick(1);
    tick(5);
    chk("s2_done_once", 32'(done_cnt - base), 1);
    chk("s2_drained", 32'(sb.size()), 0);
    chk("s2_busy_low", {31'd0, busy}, 0);
    chk("s2_csum", {24'd0, done_csum}, 0);
    base = wr_cnt;
    send(8'h42);
    tick(5);
    chk("s2_extra_ignored", 32'(wr_cnt - base), 0);
    chk("s2_no_ovf", {31'd0, overflow}, 0);
    // Scenario 5: async reset during a write cycle
    start();
    sb.push_back({12'd0, 8'h77});
    send(8'h77);
    for (int i = 0; i < 10 && !ram_clk_enable; i++) @(negedge clk);
    chk("s5_in_write", {31'd0, ram_clk_enable}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_ctl", {27'd0, busy, frame_done, overflow, ram_clk_enable, ram_write}, 0);
    chk("s5_rst_data", {4'd0, ram_address, ram_data_out, checksum}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("s5_idle", {31'd0, busy}, 0);
    base = wr_cnt;
    send(8'h99);
    tick(5);
    chk("s5_ignored", 32'(wr_cnt - base), 0);
    chk("s5_sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_store.md
Name: framebuffer_store

Overview:
Write-side engine for the framebuffer, the counterpart to framebuffer_fetch. It takes a byte stream (e.g. from the UART receiver in control_module) and writes it sequentially into the 8-bit port A of the dual-port framebuffer RAM. Each frame starts with frame_start and ends after FRAME_BYTES bytes, so a full 64x32 RGB565 image can be loaded while the display side reads port B.

Parameters:
ADDR_WIDTH, 12, byte address width of RAM port A
FRAME_BYTES, 4096, bytes per frame (64x32 pixels x 2 bytes); must be <= 2**ADDR_WIDTH
FIFO_DEPTH, 2, input skid FIFO depth in bytes (fixed at 2 for this revision)

Ports:
clk_in  input  1  single clock, same as framebuffer ClockA
reset  input  1  asynchronous, active-low (0 = reset)
rx_data  input  8  incoming byte
rx_strobe  input  1  one-cycle pulse: rx_data valid
frame_start  input  1  one-cycle pulse: arm the engine and restart at address 0
ram_address  output  ADDR_WIDTH  to framebuffer AddressA
ram_data_out  output  8  to framebuffer DataInA
ram_clk_enable  output  1  to framebuffer ClockEnA
ram_write  output  1  to framebuffer WrA
busy  output  1  high while armed (frame in progress)
frame_done  output  1  one-cycle pulse when the last byte of a frame has been written
overflow  output  1  sticky: a byte was dropped because the FIFO was full
checksum  output  8  frame checksum (see Optional Feature)

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, FIFO empty, pointer=0, overflow=0.
- FSM states:
  - IDLE: not armed; rx_strobe bytes are discarded, with no FIFO push and no overflow.
  - ARMED: if the FIFO is non-empty, pop the head: ram_address<=pointer, ram_data_out<=byte; next state WRITE. Otherwise stay in ARMED.
  - WRITE: ram_clk_enable=ram_write=1 for exactly this one cycle; pointer<=pointer+1.
    - If pointer==FRAME_BYTES-1: next state IDLE, pulse frame_done in the following cycle.
    - Otherwise: next state ARMED.
- ram_clk_enable and ram_write are registered, asserted only in WRITE, and always equal.
- ram_address and ram_data_out hold their last values outside WRITE.
- Throughput: 1 byte per 2 clocks sustained.
- FIFO rules:
  - Push on rx_strobe while the FSM is ARMED or WRITE.
  - Push and pop in the same cycle are both allowed.
  - A push to a full FIFO (with no pop that cycle) drops the byte and sets overflow.
- frame_start: takes priority over everything except reset.
  - Effect: FIFO flushed, pointer=0, overflow=0, checksum=0, next state ARMED.
  - A concurrent rx_strobe byte is dropped and does not set overflow.
  - If frame_start arrives in WRITE, that cycle's RAM write still completes; it does not increment the new pointer.
  - frame_start after the 1st..(FRAME_BYTES-1)th byte: no frame_done pulse.
- busy = (state != IDLE).
- Pointer is ADDR_WIDTH bits and never exceeds FRAME_BYTES-1.
- Bytes are stored in arrival order with no byte swapping; byte n goes to address n.

Optional Feature:
FB_STORE_CHECKSUM_EN
- Defined: checksum is an 8-bit modulo-256 sum of all bytes written in the current frame.
  - Updated in each WRITE cycle.
  - Cleared on reset and on frame_start.
  - Holds its final value while IDLE; valid in the frame_done cycle.
- Undefined: no checksum logic; checksum is tied to 8'h00.

Test Plan:
- Scenario 1: release reset, frame_start, then bytes A5, 5A, FF each 10 cycles apart -> exactly three one-cycle ClockEn&Wr pulses at addresses 0, 1, 2 with matching data; busy=1; frame_done=0.
- Scenario 2: frame_start, then 4096 bytes of value addr[7:0] spaced 3 cycles -> 4096 writes in ascending order; one frame_done pulse one cycle after the 4096th write; busy falls. A 4097th byte causes no write and overflow stays 0.
- Scenario 3: from ARMED with an empty FIFO, rx_strobe on 5 consecutive cycles with bytes 01..05 -> 01..04 written to addresses 0..3; 05 dropped; overflow=1 until the next frame_start.
- Scenario 4: frame_start after 10 bytes, then byte 3C -> 3C written at address 0; no frame_done pulse; overflow and checksum cleared.
- Scenario 5: drive reset low during a WRITE cycle -> ram_clk_enable, ram_write and all outputs go to 0 immediately. After release: IDLE, and bytes are ignored until frame_start.
- Scenario 6 (FB_STORE_CHECKSUM_EN): a 4096-byte frame of value addr[7:0] gives checksum 8'h00 at frame_done. Bytes 10, 20, F5 then frame_start give 8'h25 before the frame_start and 8'h00 after. Without the macro, checksum stays 8'h00 throughout.
